// File: rtl/banked_act_mem.sv
// Multi-bank activation buffer: logical banks mapped onto one flat dual-port RAM
// through a rotating bank map, with a 2-cycle pipelined read and a sticky range-error flag.
module banked_act_mem #(
    parameter int DATA_W     = 24,
    parameter int BANK_DEPTH = 40,
    parameter int NUM_BANKS  = 3,
    parameter int ADDR_W     = 6,
    parameter int BANK_W     = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_rd_en,
    input  logic [BANK_W-1:0] i_rd_bank,
    input  logic [ADDR_W-1:0] i_rd_addr,
    input  logic              i_wr_en,
    input  logic [BANK_W-1:0] i_wr_bank,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rotate,
    output logic              o_rd_valid,
    output logic [DATA_W-1:0] o_rd_data,
    output logic [BANK_W-1:0] o_rot_ptr,
    output logic              o_err
);
    localparam int WORDS  = NUM_BANKS * BANK_DEPTH;
    localparam int FLAT_W = $clog2(WORDS);

    logic [DATA_W-1:0] r_mem [WORDS];
    logic [DATA_W-1:0] r_mem_q;

    logic              r_s1_valid;
    logic              r_s1_oor;
    logic [FLAT_W-1:0] r_s1_addr;
    logic              r_s2_valid;
    logic              r_s2_oor;
    logic              r_rd_valid;
    logic [DATA_W-1:0] r_rd_data;
    logic [BANK_W-1:0] r_rot_ptr;
    logic              r_err;

    logic              w_rd_oor;
    logic              w_wr_oor;
    logic [FLAT_W-1:0] w_rd_flat;
    logic [FLAT_W-1:0] w_wr_flat;

    function automatic logic is_oor(input logic [BANK_W-1:0] bank, input logic [ADDR_W-1:0] addr);
        return ({1'b0, bank} >= (BANK_W+1)'(NUM_BANKS)) || ({1'b0, addr} >= (ADDR_W+1)'(BANK_DEPTH));
    endfunction

    // Only meaningful for in-range bank/addr: both operands < NUM_BANKS, so one subtract wraps.
    function automatic logic [FLAT_W-1:0] flat_addr(input logic [BANK_W-1:0] bank,
                                                    input logic [ADDR_W-1:0] addr,
                                                    input logic [BANK_W-1:0] rot);
        logic [BANK_W:0] sum;
        sum = {1'b0, bank} + {1'b0, rot};
        if (sum >= (BANK_W+1)'(NUM_BANKS))
            sum = sum - (BANK_W+1)'(NUM_BANKS);
        return FLAT_W'(sum[BANK_W-1:0]) * FLAT_W'(BANK_DEPTH) + FLAT_W'(addr);
    endfunction

    assign w_rd_oor  = is_oor(i_rd_bank, i_rd_addr);
    assign w_wr_oor  = is_oor(i_wr_bank, i_wr_addr);
    assign w_rd_flat = w_rd_oor ? '0 : flat_addr(i_rd_bank, i_rd_addr, r_rot_ptr);
    assign w_wr_flat = w_wr_oor ? '0 : flat_addr(i_wr_bank, i_wr_addr, r_rot_ptr);

    // RAM with registered read; read-before-write on a same-address collision.
    always_ff @(posedge i_clk) begin
        if (!i_rst && i_wr_en && !w_wr_oor)
            r_mem[w_wr_flat] <= i_wr_data;
        r_mem_q <= r_mem[r_s1_addr];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1_valid <= 1'b0;
            r_s1_oor   <= 1'b0;
            r_s1_addr  <= '0;
            r_s2_valid <= 1'b0;
            r_s2_oor   <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
            r_rot_ptr  <= '0;
            r_err      <= 1'b0;
        end else begin
            r_s1_valid <= i_rd_en;
            r_s1_oor   <= w_rd_oor;
            r_s1_addr  <= w_rd_flat;
            r_s2_valid <= r_s1_valid;
            r_s2_oor   <= r_s1_oor;
            r_rd_valid <= r_s2_valid;
            if (r_s2_valid)
                r_rd_data <= r_s2_oor ? '0 : r_mem_q;
            if (i_rotate)
                r_rot_ptr <= (r_rot_ptr == BANK_W'(NUM_BANKS - 1)) ? '0 : r_rot_ptr + BANK_W'(1);
            if ((i_rd_en && w_rd_oor) || (i_wr_en && w_wr_oor))
                r_err <= 1'b1;
        end
    end

    assign o_rd_valid = r_rd_valid;
    assign o_rd_data  = r_rd_data;
    assign o_rot_ptr  = r_rot_ptr;
    assign o_err      = r_err;
endmodule

// File: tb/tb_banked_act_mem.sv
// Directed self-checking bench for banked_act_mem: latency, rotation, ordering,
// range errors, reset flush and full-rate streaming.
module tb_banked_act_mem;
    logic        clk = 1'b0;
    logic        rst;
    logic        rd_en;
    logic [1:0]  rd_bank;
    logic [5:0]  rd_addr;
    logic        wr_en;
    logic [1:0]  wr_bank;
    logic [5:0]  wr_addr;
    logic [23:0] wr_data;
    logic        rotate;
    logic        rd_valid;
    logic [23:0] rd_data;
    logic [1:0]  rot_ptr;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;

    banked_act_mem dut (
        .i_clk(clk), .i_rst(rst),
        .i_rd_en(rd_en), .i_rd_bank(rd_bank), .i_rd_addr(rd_addr),
        .i_wr_en(wr_en), .i_wr_bank(wr_bank), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .i_rotate(rotate),
        .o_rd_valid(rd_valid), .o_rd_data(rd_data), .o_rot_ptr(rot_ptr), .o_err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [1:0] b, input logic [5:0] a, input logic [23:0] d);
        wr_en = 1'b1; wr_bank = b; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic pulse_rotate();
        rotate = 1'b1;
        tick();
        rotate = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [1:0] b, input logic [5:0] a,
                              input logic [23:0] exp);
        rd_en = 1'b1; rd_bank = b; rd_addr = a;
        tick();
        rd_en = 1'b0;
        check({tag, "_v_e0"}, 32'(rd_valid), 32'd0);
        tick();
        check({tag, "_v_e1"}, 32'(rd_valid), 32'd0);
        tick();
        check({tag, "_v_e2"}, 32'(rd_valid), 32'd1);
        check({tag, "_data"}, 32'(rd_data), 32'(exp));
    endtask

    initial begin
        int pulses;
        logic [23:0] exp_d;
        rst = 1'b1; rd_en = 1'b0; rd_bank = '0; rd_addr = '0;
        wr_en = 1'b0; wr_bank = '0; wr_addr = '0; wr_data = '0; rotate = 1'b0;
        tick(); tick();
        check("rst_valid", 32'(rd_valid), 32'd0);
        check("rst_data", 32'(rd_data), 32'd0);
        check("rst_rot", 32'(rot_ptr), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst = 1'b0;

        // 1: basic latency
        write(2'd0, 6'd5, 24'hABCDEF);
        read_check("t1", 2'd0, 6'd5, 24'hABCDEF);
        tick(); tick();
        check("t1_hold_v", 32'(rd_valid), 32'd0);
        check("t1_hold_d", 32'(rd_data), 32'hABCDEF);

        // 2: rotation
        write(2'd1, 6'd0, 24'h000111);
        pulse_rotate();
        check("t2_rot1", 32'(rot_ptr), 32'd1);
        read_check("t2", 2'd0, 6'd0, 24'h000111);
        pulse_rotate();
        check("t2_rot2", 32'(rot_ptr), 32'd2);
        pulse_rotate();
        check("t2_wrap", 32'(rot_ptr), 32'd0);

        // 3: same-edge write is visible, next-edge write is not
        write(2'd2, 6'd39, 24'h000222);
        rd_en = 1'b1; rd_bank = 2'd2; rd_addr = 6'd39;
        wr_en = 1'b1; wr_bank = 2'd2; wr_addr = 6'd39; wr_data = 24'h000333;
        tick();
        rd_en = 1'b0; wr_en = 1'b0;
        tick(); tick();
        check("t3_same_v", 32'(rd_valid), 32'd1);
        check("t3_same_d", 32'(rd_data), 32'h333);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        write(2'd2, 6'd39, 24'h000444);
        tick();
        check("t3_late_v", 32'(rd_valid), 32'd1);
        check("t3_late_d", 32'(rd_data), 32'h333);
        read_check("t3_after", 2'd2, 6'd39, 24'h000444);
        check("t3_err", 32'(err), 32'd0);

        // 4: out of range (addr 40 of bank0 would alias bank1 addr0)
        write(2'd0, 6'd40, 24'h00DEAD);
        check("t4_wr_err", 32'(err), 32'd1);
        read_check("t4_alias", 2'd1, 6'd0, 24'h000111);
        read_check("t4_rdoor", 2'd3, 6'd0, 24'h000000);
        tick();
        check("t4_sticky", 32'(err), 32'd1);

        // 5: reset flushes in-flight reads
        pulse_rotate();
        check("t5_rot_pre", 32'(rot_ptr), 32'd1);
        rd_en = 1'b1; rd_bank = 2'd2; rd_addr = 6'd5;
        tick(); tick(); tick();
        rd_en = 1'b0; rst = 1'b1;
        wr_en = 1'b1; wr_bank = 2'd0; wr_addr = 6'd5; wr_data = 24'h0BAD00;
        tick();
        rst = 1'b0; wr_en = 1'b0;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            check("t5_rot", 32'(rot_ptr), 32'd0);
            if (rd_valid) pulses++;
            tick();
        end
        check("t5_pulses", 32'(pulses), 32'd0);
        check("t5_err", 32'(err), 32'd0);
        read_check("t5_keep0", 2'd0, 6'd5, 24'hABCDEF);
        read_check("t5_keep2", 2'd2, 6'd39, 24'h000444);

        // 6: streaming, rotate sampled with read 20
        for (int i = 0; i < 40; i++) write(2'd0, 6'(i), 24'h001000 + 24'(i));
        for (int i = 0; i < 40; i++) write(2'd1, 6'(i), 24'h002000 + 24'(i));
        for (int c = 0; c < 42; c++) begin
            rd_en = (c < 40); rd_bank = 2'd0; rd_addr = 6'(c % 40);
            rotate = (c == 20);
            tick();
            rd_en = 1'b0; rotate = 1'b0;
            if (c < 2) begin
                check("t6_lead", 32'(rd_valid), 32'd0);
            end else begin
                exp_d = (c - 2 <= 20) ? 24'h001000 + 24'(c - 2) : 24'h002000 + 24'(c - 2);
                check($sformatf("t6_v%0d", c - 2), 32'(rd_valid), 32'd1);
                check($sformatf("t6_d%0d", c - 2), 32'(rd_data), 32'(exp_d));
            end
        end
        tick();
        check("t6_tail", 32'(rd_valid), 32'd0);
        check("t6_rot", 32'(rot_ptr), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
